host_sequencer: RTL

Host-side initiator for the processor's `req`/`done` run handshake. It streams a data image into data memory through the memory write port, then pulses `req` and waits for `done` under a timeout. On completion it reads a fixed result window back out of data memory and presents it as a ready/valid byte stream. It sits between the test/host environment and the processor core plus its data memory, and owns the memory port whenever the core is not running.

---
 rtl/host_sequencer_pkg.sv | 15 +
 rtl/host_sequencer_res_fifo.sv | 32 +++
 rtl/host_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/host_sequencer_pkg.sv
// host_seq_pkg: sequencer state encoding and default parameter values.
package host_seq_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } host_seq_state_t;
    localparam int ADDR_W_DEF   = 8;
    localparam int LOAD_LEN_DEF = 64;
    localparam int RES_BASE_DEF = 64;
    localparam int RES_LEN_DEF  = 8;
    localparam int TIMEOUT_DEF  = 4096;
endpackage

// File: rtl/host_sequencer_res_fifo.sv
// res_fifo: 2-entry, 8-bit result FIFO buffering read-back bytes against res_ready stalls.
module res_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    logic [7:0] mem [2];
    logic       wp, rp;
    logic [1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
    assign dout  = mem[rp];
    assign full  = cnt[1];
    assign empty = cnt == 2'd0;
endmodule

// File: rtl/host_sequencer.sv
// host_sequencer: loads data memory, kicks the core via req/done with a timeout, streams results back.
// Optional HOST_SEQ_CYCLE_CNT_EN adds the run_cycles output.
module host_sequencer
    import host_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOAD_LEN = LOAD_LEN_DEF,
    parameter int RES_BASE = RES_BASE_DEF,
    parameter int RES_LEN  = RES_LEN_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data,
    output logic              req,
    input  logic              done,
    output logic              res_valid,
    output logic [7:0]        res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              timeout_err
`ifdef HOST_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]       run_cycles
`endif
);
    localparam int RW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   LOAD_LAST = (ADDR_W + 1)'(LOAD_LEN - 1);
    localparam logic [ADDR_W:0]   RES_LAST  = (ADDR_W + 1)'(RES_LEN - 1);
    localparam logic [ADDR_W:0]   RES_CNT   = (ADDR_W + 1)'(RES_LEN);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(RES_BASE);
    localparam logic [RW-1:0]     TMO       = RW'(TIMEOUT);

    host_seq_state_t state;
    logic [ADDR_W:0] cnt, issued, popped;
    logic [RW-1:0]   run_cnt;
    logic            armed, inflight, err, fin, tmo, issue, pop, f_full, f_empty;
    logic [7:0]      f_dout;

    assign fin         = armed && done;
    assign tmo         = state == RUN && run_cnt == TMO && !fin;
    assign src_ready   = state == LOAD;
    assign mem_wr_en   = src_ready && src_valid;
    assign mem_wr_data = mem_wr_en ? src_data : 8'h00;
    assign mem_addr    = state == LOAD ? cnt[ADDR_W-1:0] : state == DRAIN ? BASE + issued[ADDR_W-1:0] : '0;
    assign req         = state == KICK;
    assign busy        = state != IDLE;
    assign timeout_err = err || tmo;
    // A byte returning into an empty FIFO is presented directly so DRAIN streams 1 byte/cycle.
    assign res_valid   = !f_empty || inflight;
    assign res_data    = !f_empty ? f_dout : inflight ? mem_rd_data : 8'h00;
    assign pop         = res_valid && res_ready;
    assign issue       = state == DRAIN && issued != RES_CNT && !f_full && !(inflight && !f_empty);

    res_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight && !(f_empty && res_ready)),
        .pop   (pop && !f_empty),
        .din   (mem_rd_data),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            issued   <= '0;
            popped   <= '0;
            run_cnt  <= '0;
            armed    <= 1'b0;
            inflight <= 1'b0;
            err      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) issued <= issued + 1'b1;
            if (pop) popped <= popped + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    cnt   <= '0;
                    err   <= 1'b0;
                end
                LOAD: if (mem_wr_en) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LOAD_LAST) state <= KICK;
                end
                KICK: begin
                    armed   <= 1'b0;
                    run_cnt <= RW'(1);
                    state   <= RUN;
                end
                RUN: begin
                    // armed only after done has been seen low, so a stale done cannot complete the run
                    run_cnt <= run_cnt + 1'b1;
                    if (!done) armed <= 1'b1;
                    if (fin) begin
                        state  <= DRAIN;
                        issued <= '0;
                        popped <= '0;
                    end else if (tmo) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                DRAIN: if (pop && popped == RES_LAST) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HOST_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc;
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc        <= '0;
            run_cycles <= '0;
        end else if (state == KICK) begin
            cyc <= 16'd1;
        end else if (state == RUN) begin
            cyc <= &cyc ? cyc : cyc + 1'b1;
            if (fin || tmo) run_cycles <= cyc;
        end
    end
`endif
endmodule
